// File: rtl/hsv_pkg.sv
// Shared HSV/RGB types, converter latency and the 8-bit HSV->RGB transfer function.
package hsv_pkg;
  typedef struct packed {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } hsv_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int HSV2RGB_LAT = 4;

  // Six hue sectors of width 256 on h*6; chroma and ramps rounded up so pure hues hit 0xFF.
  function automatic rgb_t hsv2rgb(hsv_t x);
    logic [10:0] h6;
    logic [15:0] t;
    logic [7:0]  c, m, rise, fall;
    rgb_t        y;
    h6   = 11'(x.h) * 11'd6;
    t    = 16'(x.v) * 16'(x.s) + 16'd255;
    c    = t[15:8];
    m    = x.v - c;
    t    = 16'(c) * (16'(h6[7:0]) + 16'd1) + 16'd255;
    rise = t[15:8];
    fall = c - rise;
    case (h6[10:8])
      3'd0:    y = '{r: c,    g: rise, b: 8'd0};
      3'd1:    y = '{r: fall, g: c,    b: 8'd0};
      3'd2:    y = '{r: 8'd0, g: c,    b: rise};
      3'd3:    y = '{r: 8'd0, g: fall, b: c};
      3'd4:    y = '{r: rise, g: 8'd0, b: c};
      default: y = '{r: c,    g: 8'd0, b: fall};
    endcase
    y.r = y.r + m;
    y.g = y.g + m;
    y.b = y.b + m;
    return y;
  endfunction
endpackage

// File: rtl/hsv2rgb_8u.sv
// Fixed-latency HSV->RGB converter; never stalls, LAT clocks from hsv_in to outputs.
module hsv2rgb_8u import hsv_pkg::*; #(
  parameter int LAT = HSV2RGB_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] hsv_in,
  input  logic        in_valid,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        out_valid
);
  rgb_t           pipe [LAT];
  logic [LAT-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      pipe[0]     <= hsv2rgb(hsv_in);
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  assign {red_out, green_out, blue_out} = pipe[LAT-1];
  assign out_valid = vld_pipe[LAT-1];
endmodule

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: first asserted req at or above ptr, modulo N.
module rr_pick_n #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int o = 0; o < N; o++) begin
      j = (int'(ptr) + o) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/hsv_conv_arbiter.sv
// Round-robin sharing of one fixed-latency HSV->RGB converter among N_REQ requesters,
// with requester tags carried alongside the converter pipeline.
module hsv_conv_arbiter import hsv_pkg::*; #(
  parameter int N_REQ    = 4,
  parameter int CONV_LAT = HSV2RGB_LAT,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*24-1:0] req_hsv,
  output logic [23:0]         cv_hsv,
  output logic                cv_valid,
  input  logic [23:0]         cv_rgb,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [23:0]         rsp_rgb,
  output logic                busy
);
  logic [N_REQ-1:0]               grant;
  logic [ID_W-1:0]                pick_idx, rr_ptr, cv_id;
  logic                           pick_any, xfer;
  logic [CONV_LAT-1:0]            vld_pipe;
  logic [CONV_LAT-1:0][ID_W-1:0]  id_pipe;

  rr_pick_n #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = pick_any & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cv_valid <= 1'b0;
      cv_hsv   <= '0;
      cv_id    <= '0;
    end else begin
      cv_valid <= xfer;
      if (xfer) begin
        rr_ptr <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + ID_W'(1);
        cv_hsv <= req_hsv[pick_idx*24 +: 24];
        cv_id  <= pick_idx;
      end
    end
  end

  // Tail of the tag pipeline lines up with cv_rgb for the same request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_rgb   <= '0;
    end else begin
      vld_pipe[0] <= cv_valid;
      id_pipe[0]  <= cv_id;
      for (int i = 1; i < CONV_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      rsp_valid <= vld_pipe[CONV_LAT-1] ? (N_REQ'(1) << id_pipe[CONV_LAT-1]) : '0;
      if (vld_pipe[CONV_LAT-1]) begin
        rsp_id  <= id_pipe[CONV_LAT-1];
        rsp_rgb <= cv_rgb;
      end
    end
  end

  assign busy = cv_valid | (|vld_pipe) | (|rsp_valid);
endmodule

// File: tb/tb_hsv_conv_arbiter.sv
// Directed + random bench for hsv_conv_arbiter driving a real hsv2rgb_8u converter.
module tb_hsv_conv_arbiter;
  import hsv_pkg::*;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [95:0] req_hsv;
  logic [23:0] cv_hsv, cv_rgb, rsp_rgb;
  logic        cv_valid, busy, conv_ov;
  logic [1:0]  rsp_id;
  logic [7:0]  rr, gg, bb;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [23:0] rgb;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0, n_err = 0, cyc = 0, m_ptr = 0;

  hsv_conv_arbiter #(.N_REQ(4), .CONV_LAT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_hsv(req_hsv),
    .cv_hsv(cv_hsv), .cv_valid(cv_valid), .cv_rgb(cv_rgb), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_rgb(rsp_rgb), .busy(busy)
  );

  // Converter is never reset so stale data keeps flushing through it after an arbiter reset.
  hsv2rgb_8u #(.LAT(4)) u_conv (
    .clk(clk), .rst(1'b0), .hsv_in(cv_hsv), .in_valid(cv_valid),
    .red_out(rr), .green_out(gg), .blue_out(bb), .out_valid(conv_ov)
  );
  assign cv_rgb = {rr, gg, bb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: arbitration check + scoreboard push, then edge, then response/busy check.
  task automatic cycle();
    logic [3:0] exp_rdy;
    logic [3:0] exp_rsp;
    logic       exp_busy;
    int         gid, j;
    ent_t       e;
    #1;
    exp_rdy = '0;
    gid     = 0;
    if (!rst)
      for (int o = 0; o < 4; o++) begin
        j = (m_ptr + o) % 4;
        if (exp_rdy == 4'd0 && req_valid[j]) begin
          exp_rdy[j] = 1'b1;
          gid        = j;
        end
      end
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    chk("ready_wo_valid", 32'(req_ready & ~req_valid), 32'd0);
    if (exp_rdy != 4'd0) begin
      sb.push_back('{cyc + 6, 2'(gid), hsv2rgb(req_hsv[24*gid +: 24])});
      m_ptr = (gid + 1) % 4;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_busy = 1'b0;
    if (sb.size() > 0) exp_busy = (sb[0].due - 5 <= cyc);
    chk("busy", 32'(busy), 32'(exp_busy));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e       = sb.pop_front();
      exp_rsp = 4'd1 << e.id;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
    end else begin
      chk("no_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    sb.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_hsv   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_cv_valid", 32'(cv_valid), 32'd0);
    chk("rst_cv_hsv", 32'(cv_hsv), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_rgb", 32'(rsp_rgb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Test 1: single request from req0, 6-cycle turnaround.
    req_hsv[0 +: 24] = 24'h00FFFF;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    cycle();
    chk("t1_cv_valid", 32'(cv_valid), 32'd1);
    chk("t1_cv_hsv", 32'(cv_hsv), 32'h00FFFF);
    req_valid = '0;
    repeat (5) cycle();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_rgb", 32'(rsp_rgb), 32'hFF0100);
    cycle();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_cv_hold", 32'(cv_hsv), 32'h00FFFF);

    // Test 2: req2 then req1 back-to-back.
    req_hsv[48 +: 24] = 24'h80FFFF;
    req_hsv[24 +: 24] = 24'h000080;
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t2_id2", 32'(rsp_id), 32'd2);
    chk("t2_rgb2", 32'(rsp_rgb), 32'h00FEFF);
    cycle();
    chk("t2_id1", 32'(rsp_id), 32'd1);
    chk("t2_rgb1", 32'(rsp_rgb), 32'h808080);
    repeat (2) cycle();

    // Test 3: all requesters valid for 12 clocks from reset.
    do_reset();
    req_hsv = {24'h2A80C0, 24'hC0FF40, 24'h55FFFF, 24'h10A0F0};
    req_valid = 4'hF;
    for (int n = 0; n < 12; n++) begin
      #1 chk("t3_grant", 32'(req_ready), 32'(4'd1 << (n % 4)));
      cycle();
    end
    req_valid = '0;
    repeat (8) cycle();

    // Test 4: rr_ptr=3 then only req3/req0 valid -> 3, wrap to 0, ptr ends at 1.
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b1001;
    #1 chk("t4_g3", 32'(req_ready), 32'h8);
    cycle();
    #1 chk("t4_g0", 32'(req_ready), 32'h1);
    cycle();
    req_valid = 4'hF;
    #1 chk("t4_ptr1", 32'(req_ready), 32'h2);
    cycle();
    req_valid = '0;
    repeat (8) cycle();

    // Test 5: three grants, then a 1-clk reset mid-flight.
    req_valid = 4'hF;
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cv_valid", 32'(cv_valid), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    req_valid = '0;
    repeat (8) cycle();
    req_valid = 4'hF;
    #1 chk("t5_first_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    repeat (8) cycle();

    // Test 6: random traffic with idle gaps against the scoreboard.
    for (int n = 0; n < 1000; n++) begin
      req_hsv   = {$urandom, $urandom, $urandom};
      req_valid = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cycle();
    end
    req_valid = '0;
    repeat (8) cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
